// File: rtl/cordic_pkg.sv
// Shared constants and fixed-point types for the CORDIC front end.
// Constants are rounded to nearest using wide integer arithmetic so the
// package stays synthesizable for any FRAC_BITS up to about 60.
package cordic_pkg;

  localparam int FRAC_BITS_DEFAULT = 20;

  // Default-width fixed-point types: Q3.F angle in, Q2.F values out.
  typedef logic signed [FRAC_BITS_DEFAULT+2:0] angle_t;
  typedef logic signed [FRAC_BITS_DEFAULT+1:0] coord_t;

  // round(pi * 2^fracBits)
  function automatic logic [63:0] pi_fx(input int fracBits);
    logic [127:0] num;
    num = 128'd3141592653589793238 << fracBits;
    num = num + 128'd500000000000000000;
    return 64'(num / 128'd1000000000000000000);
  endfunction

  // round(pi/2 * 2^fracBits)
  function automatic logic [63:0] half_pi_fx(input int fracBits);
    logic [127:0] num;
    num = 128'd3141592653589793238 << fracBits;
    num = num + 128'd1000000000000000000;
    return 64'(num / 128'd2000000000000000000);
  endfunction

  // round(0.6072529350 * 2^fracBits), the CORDIC gain compensation
  function automatic logic [63:0] k_fx(input int fracBits);
    logic [127:0] num;
    num = 128'd6072529350 << fracBits;
    num = num + 128'd5000000000;
    return 64'(num / 128'd10000000000);
  endfunction

endpackage

// File: rtl/cordic_fold.sv
// Combinational quadrant fold: brings an angle into [-pi/2, pi/2] by
// subtracting or adding pi, and tells downstream to negate the result.
// Optional range check enabled by CORDIC_PREP_RANGE_CHK_EN.
module cordic_fold
  import cordic_pkg::*;
#(
  parameter int FRAC_BITS = 20
) (
  input  logic signed [FRAC_BITS+2:0] angle_i,
  output logic signed [FRAC_BITS+1:0] z_o,
  output logic                        flip_o,
  output logic                        err_o
);

  localparam int AW = FRAC_BITS + 3;

  localparam logic signed [AW-1:0] PI_C       = AW'(pi_fx(FRAC_BITS));
  localparam logic signed [AW-1:0] HALF_PI_C  = AW'(half_pi_fx(FRAC_BITS));
  localparam logic signed [AW-1:0] NEG_HALF_C = -HALF_PI_C;
`ifdef CORDIC_PREP_RANGE_CHK_EN
  localparam logic signed [AW-1:0] NEG_PI_C   = -PI_C;
`endif

  logic signed [AW-1:0] angleMinusPi;
  logic signed [AW-1:0] anglePlusPi;

  assign angleMinusPi = angle_i - PI_C;
  assign anglePlusPi  = angle_i + PI_C;

  // Fold decision; the sum is formed one bit wider and truncated on output.
  always_comb begin
    z_o    = angle_i[AW-2:0];
    flip_o = 1'b0;
    err_o  = 1'b0;
    if (angle_i > HALF_PI_C) begin
      z_o    = angleMinusPi[AW-2:0];
      flip_o = 1'b1;
    end else if (angle_i < NEG_HALF_C) begin
      z_o    = anglePlusPi[AW-2:0];
      flip_o = 1'b1;
    end
`ifdef CORDIC_PREP_RANGE_CHK_EN
    if ((angle_i >= PI_C) || (angle_i < NEG_PI_C)) begin
      z_o    = '0;
      flip_o = 1'b0;
      err_o  = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/cordic_prep.sv
// CORDIC pre-processing stage: folds the input angle into the convergence
// range and presents the initial (x, y, z) triple for the iteration chain.
// Two-register elastic pipeline with valid/ready on both sides.
// Define CORDIC_PREP_RANGE_CHK_EN to flag angles outside [-pi, pi).
module cordic_prep
  import cordic_pkg::*;
#(
  parameter int FRAC_BITS = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FRAC_BITS+2:0]  angle_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FRAC_BITS+1:0]  x_out,
  output logic [FRAC_BITS+1:0]  y_out,
  output logic [FRAC_BITS+1:0]  z_out,
  output logic                  flip_out,
  output logic                  err_out
);

  localparam int OW = FRAC_BITS + 2;
  localparam logic [OW-1:0] K_C = OW'(k_fx(FRAC_BITS));

  logic signed [OW-1:0] foldZ;
  logic                 foldFlip;
  logic                 foldErr;

  logic                 aValid_q, aValid_d;
  logic [OW-1:0]        aZ_q;
  logic                 aFlip_q;
  logic                 aErr_q;

  logic                 bValid_q, bValid_d;
  logic [OW-1:0]        x_q;
  logic [OW-1:0]        y_q;
  logic [OW-1:0]        z_q;
  logic                 flip_q;
  logic                 err_q;

  logic                 aLoad;
  logic                 bLoad;

  cordic_fold #(
    .FRAC_BITS (FRAC_BITS)
  ) uFold (
    .angle_i (angle_in),
    .z_o     (foldZ),
    .flip_o  (foldFlip),
    .err_o   (foldErr)
  );

  // Handshake: a stage advances when empty or when the stage after it drains.
  always_comb begin
    bLoad    = !bValid_q || out_ready;
    aLoad    = !aValid_q || bLoad;
    aValid_d = aLoad ? in_valid : aValid_q;
    bValid_d = bLoad ? aValid_q : bValid_q;
    in_ready = aLoad;
  end

  // Stage A captures the accepted angle together with its fold outcome.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aValid_q <= 1'b0;
      aZ_q     <= '0;
      aFlip_q  <= 1'b0;
      aErr_q   <= 1'b0;
    end else begin
      aValid_q <= aValid_d;
      if (aLoad && in_valid) begin
        aZ_q    <= foldZ;
        aFlip_q <= foldFlip;
        aErr_q  <= foldErr;
      end
    end
  end

  // Stage B drives the output triple; it holds while stalled downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bValid_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      flip_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      bValid_q <= bValid_d;
      if (bLoad && aValid_q) begin
        x_q    <= K_C;
        y_q    <= '0;
        z_q    <= aZ_q;
        flip_q <= aFlip_q;
        err_q  <= aErr_q;
      end
    end
  end

  assign out_valid = bValid_q;
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign z_out     = z_q;
  assign flip_out  = flip_q;
  assign err_out   = err_q;

endmodule

// File: tb/tb_cordic_prep.sv
// Scoreboard testbench for cordic_prep (FRAC_BITS = 20).
// Expected triples are computed from the fold rules with plain integer
// arithmetic and queued at acceptance; a negedge monitor pops and compares.
module tb_cordic_prep;

  localparam int FB = 20;
  localparam longint PI_V   = 64'sd3294199;
  localparam longint HALF_V = 64'sd1647099;
  localparam logic [21:0] K_V = 22'h09B74F;

  typedef struct packed {
    logic [21:0] z;
    logic        flip;
    logic        err;
  } expT;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [22:0] angle_in;
  logic        out_valid;
  logic        out_ready;
  logic [21:0] x_out;
  logic [21:0] y_out;
  logic [21:0] z_out;
  logic        flip_out;
  logic        err_out;

  int  checks;
  int  failures;
  int  acceptCount;
  expT expQ[$];

  logic        stallPrev;
  logic [21:0] prevZ;
  logic        prevFlip;
  logic        prevErr;

  cordic_prep #(
    .FRAC_BITS (FB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .angle_in  (angle_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out),
    .flip_out  (flip_out),
    .err_out   (err_out)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference fold: angle as an integer, compared against rounded constants.
  function automatic expT refModel(input logic [22:0] a);
    expT    e;
    longint v;
    longint z;
    v = longint'($signed(a));
    z = v;
    e.flip = 1'b0;
    e.err  = 1'b0;
    if (v > HALF_V) begin
      z = v - PI_V;
      e.flip = 1'b1;
    end else if (v < -HALF_V) begin
      z = v + PI_V;
      e.flip = 1'b1;
    end
`ifdef CORDIC_PREP_RANGE_CHK_EN
    if (v >= PI_V || v < -PI_V) begin
      z = 0;
      e.flip = 1'b0;
      e.err  = 1'b1;
    end
`endif
    e.z = z[21:0];
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Present one angle and hold it until accepted; the expectation is queued on acceptance.
  task automatic applyStimulus(input logic [22:0] a);
    int waitCycles;
    bit done;
    waitCycles = 0;
    done = 1'b0;
    angle_in = a;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        expQ.push_back(refModel(a));
        acceptCount++;
        done = 1'b1;
      end else begin
        waitCycles++;
        if (waitCycles > 100) begin
          checkOutput("accept_timeout", 32'(in_ready), 32'd1);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drainPipe();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (expQ.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
  endtask

  // Monitor: compare every transfer and confirm outputs hold while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      stallPrev = 1'b0;
    end else begin
      if (stallPrev) begin
        checkOutput("stall_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_z", 32'(z_out), 32'(prevZ));
        checkOutput("stall_flip", 32'(flip_out), 32'(prevFlip));
        checkOutput("stall_err", 32'(err_out), 32'(prevErr));
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          expT e;
          e = expQ.pop_front();
          checkOutput("x_out", 32'(x_out), 32'(K_V));
          checkOutput("y_out", 32'(y_out), 32'd0);
          checkOutput("z_out", 32'(z_out), 32'(e.z));
          checkOutput("flip_out", 32'(flip_out), 32'(e.flip));
          checkOutput("err_out", 32'(err_out), 32'(e.err));
        end
      end
      stallPrev = out_valid && !out_ready;
      prevZ     = z_out;
      prevFlip  = flip_out;
      prevErr   = err_out;
    end
  end

  logic [22:0] directedVec [9];
  logic        randDone;

  initial begin
    checks      = 0;
    failures    = 0;
    acceptCount = 0;
    stallPrev   = 1'b0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    angle_in    = '0;
    out_ready   = 1'b1;
    randDone    = 1'b0;

    directedVec[0] = 23'h200000;
    directedVec[1] = 23'h600000;
    directedVec[2] = 23'h1921FB;
    directedVec[3] = 23'h66DE05;
    directedVec[4] = 23'h4DBC09;
    directedVec[5] = 23'h3243F7;
    directedVec[6] = 23'h1921FC;
    directedVec[7] = 23'h3FFFFF;
    directedVec[8] = 23'h400000;

    // Reset state
    #12;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_x_out", 32'(x_out), 32'd0);
    checkOutput("rst_z_out", 32'(z_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Angle 0: out_valid in the second cycle after the accepting edge.
    applyStimulus(23'h000000);
    checkOutput("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_cycle2_valid", 32'(out_valid), 32'd1);
    drainPipe();

    // Directed fold boundaries, streamed back to back.
    for (int i = 0; i < 9; i++) applyStimulus(directedVec[i]);
    drainPipe();

    // Stream of 8 with a 3-cycle downstream stall from the start.
    fork
      begin
        for (int i = 0; i < 8; i++) applyStimulus(23'($urandom()));
      end
      begin
        int base;
        base = acceptCount;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        checkOutput("stall_accepts", 32'(acceptCount - base), 32'd2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drainPipe();

    // Asynchronous reset with two items in flight.
    applyStimulus(23'h200000);
    applyStimulus(23'h600000);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_z", 32'(z_out), 32'd0);
    checkOutput("async_rst_flip", 32'(flip_out), 32'd0);
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("in_ready_after_rst2", 32'(in_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("no_stale_output", 32'(out_valid), 32'd0);

    // Random angles against random backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) applyStimulus(23'($urandom()));
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drainPipe();
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
